// File: rtl/ctr_pkg.sv
// Shared types for the programmable up/down counter: overflow modes and run/halt state.
package ctr_pkg;

  typedef enum logic [1:0] {
    CTR_WRAP    = 2'd0,
    CTR_SAT     = 2'd1,
    CTR_ONESHOT = 2'd2,
    CTR_RSVD    = 2'd3
  } ctr_mode_e;

  typedef enum logic {
    CTR_RUN  = 1'b0,
    CTR_HALT = 1'b1
  } ctr_state_e;

endpackage

// File: rtl/ctr_next_calc.sv
// Combinational next-count for one enabled update: applies step s in the chosen direction
// and resolves overflow/underflow according to the mode.
module ctr_next_calc
  import ctr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  ctr_mode_e        mode,
  output logic [WIDTH-1:0] next,
  output logic             ovf_nxt,
  output logic             udf_nxt,
  output logic             hit_terminal
);

  logic [WIDTH:0] cnt_x, lim_x, sum, diff, wrap_up, wrap_dn;

  // All arithmetic in WIDTH+1 bits; s <= limit keeps every wrap result in range.
  assign cnt_x   = {1'b0, count};
  assign lim_x   = {1'b0, limit};
  assign sum     = cnt_x + s;
  assign diff    = cnt_x - s;
  assign wrap_up = sum - lim_x - 1'b1;
  assign wrap_dn = cnt_x + lim_x + 1'b1 - s;

  always_comb begin
    next         = count;
    ovf_nxt      = 1'b0;
    udf_nxt      = 1'b0;
    hit_terminal = 1'b0;
    if (up_down) begin
      if (sum > lim_x) begin
        ovf_nxt      = 1'b1;
        hit_terminal = 1'b1;
        if (mode == CTR_SAT || mode == CTR_ONESHOT) next = limit;
        else                                        next = wrap_up[WIDTH-1:0];
      end else begin
        next         = sum[WIDTH-1:0];
        hit_terminal = (s != '0) && (sum == lim_x);
      end
    end else begin
      if (s > cnt_x) begin
        udf_nxt      = 1'b1;
        hit_terminal = 1'b1;
        if (mode == CTR_SAT || mode == CTR_ONESHOT) next = '0;
        else                                        next = wrap_dn[WIDTH-1:0];
      end else begin
        next         = diff[WIDTH-1:0];
        hit_terminal = (s != '0) && (s == cnt_x);
      end
    end
  end

endmodule

// File: rtl/prog_updown_counter.sv
// Up/down counter with programmable terminal value, variable step and wrap/sat/one-shot
// overflow handling. Holds count, pulse flags and the RUN/HALT state.
module prog_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              ovf,
  output logic              udf,
  output logic              done
);

  ctr_mode_e        mode_e;
  ctr_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH:0]   step_x, lim_x, s;
  logic [WIDTH-1:0] calc_next;
  logic             calc_ovf, calc_udf, calc_hit;

  assign mode_e = ctr_mode_e'(mode);
  assign step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign lim_x  = {1'b0, limit};
  assign s      = (step_x > lim_x) ? lim_x : step_x;

  ctr_next_calc #(.WIDTH(WIDTH)) u_calc (
    .count        (count_q),
    .s            (s),
    .limit        (limit),
    .up_down      (up_down),
    .mode         (mode_e),
    .next         (calc_next),
    .ovf_nxt      (calc_ovf),
    .udf_nxt      (calc_udf),
    .hit_terminal (calc_hit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (!load_n) begin
      count_d = (data_load > limit) ? limit : data_load;
      state_d = CTR_RUN;
    end else begin
      case (state_q)
        CTR_RUN: begin
          if (ce) begin
            // Limit lowered below the current count: pull back to the new terminal.
            if (count_q > limit) begin
              count_d = limit;
              ovf_d   = 1'b1;
            end else begin
              count_d = calc_next;
              ovf_d   = calc_ovf;
              udf_d   = calc_udf;
              if (calc_hit && mode_e == CTR_ONESHOT) state_d = CTR_HALT;
            end
          end
        end
        CTR_HALT: begin
          if (mode_e != CTR_ONESHOT) state_d = CTR_RUN;
        end
        default: state_d = CTR_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CTR_RUN;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count_out = count_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign done      = (state_q == CTR_HALT);
  assign max_count = (count_q >= limit);
  assign zero      = (count_q == '0);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter (WIDTH=4, STEP_W=3) with hand-computed expectations.
module tb_prog_updown_counter;
  import ctr_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 3;

  logic              clk = 1'b0;
  logic              rst_n, load_n, ce, up_down;
  logic [WIDTH-1:0]  data_load, limit;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count_out;
  logic              max_count, zero, ovf, udf, done;

  int total = 0;
  int bad   = 0;

  prog_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_n    (load_n),
    .data_load (data_load),
    .ce        (ce),
    .up_down   (up_down),
    .step      (step),
    .mode      (mode),
    .limit     (limit),
    .count_out (count_out),
    .max_count (max_count),
    .zero      (zero),
    .ovf       (ovf),
    .udf       (udf),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load_n = 1'b0; data_load = v;
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load_n = 1'b1; ce = 1'b0; up_down = 1'b1;
    data_load = '0; limit = 4'd9; step = 3'd1; mode = CTR_WRAP;
    tick();
    rst_n = 1'b1;

    // T1: reset from a non-zero count, with ce active
    do_load(4'd7);
    chk("preload7", count_out, 7);
    rst_n = 1'b0; ce = 1'b1;
    tick();
    rst_n = 1'b1; ce = 1'b0;
    chk("t1_count", count_out, 0);
    chk("t1_zero", zero, 1);
    chk("t1_ovf", ovf, 0);
    chk("t1_udf", udf, 0);
    chk("t1_done", done, 0);
    chk("t1_max", max_count, 0);

    // T2: WRAP up 8+3 past limit 9 -> 1
    do_load(4'd8);
    mode = CTR_WRAP; up_down = 1'b1; step = 3'd3; ce = 1'b1;
    tick();
    chk("t2_count", count_out, 1);
    chk("t2_ovf", ovf, 1);
    ce = 1'b0;
    tick();
    chk("t2_count_hold", count_out, 1);
    chk("t2_ovf_clr", ovf, 0);

    // T3: SAT down 2-3 -> 0 with udf
    do_load(4'd2);
    mode = CTR_SAT; up_down = 1'b0; step = 3'd3; ce = 1'b1;
    tick();
    chk("t3_count", count_out, 0);
    chk("t3_udf", udf, 1);
    chk("t3_zero", zero, 1);
    tick();
    chk("t3_count_hold", count_out, 0);
    chk("t3_udf_again", udf, 1);
    ce = 1'b0;

    // T4: ONESHOT exactly reaching limit halts without ovf
    do_load(4'd7);
    mode = CTR_ONESHOT; up_down = 1'b1; step = 3'd2; ce = 1'b1;
    tick();
    chk("t4_count", count_out, 9);
    chk("t4_done", done, 1);
    chk("t4_ovf", ovf, 0);
    chk("t4_max", max_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_halt_count", count_out, 9);
      chk("t4_halt_done", done, 1);
    end
    load_n = 1'b0; data_load = 4'd3;
    tick();
    load_n = 1'b1;
    chk("t4_load_count", count_out, 3);
    chk("t4_load_done", done, 0);

    // ONESHOT overflow then release by mode change (count unchanged)
    step = 3'd7;
    tick();
    chk("os_ovf_count", count_out, 9);
    chk("os_ovf", ovf, 1);
    chk("os_ovf_done", done, 1);
    mode = CTR_WRAP; ce = 1'b0;
    tick();
    chk("os_release_done", done, 0);
    chk("os_release_count", count_out, 9);
    chk("os_release_ovf", ovf, 0);

    // T5: load above limit clamps, and wins over ce
    load_n = 1'b0; data_load = 4'd12; ce = 1'b1; step = 3'd1;
    tick();
    load_n = 1'b1; ce = 1'b0;
    chk("t5_count", count_out, 9);
    chk("t5_max", max_count, 1);
    chk("t5_ovf", ovf, 0);

    // T6: limit lowered below count clamps with ovf
    do_load(4'd8);
    limit = 4'd5; mode = CTR_WRAP; up_down = 1'b1; step = 3'd1; ce = 1'b1;
    tick();
    chk("t6_clamp_count", count_out, 5);
    chk("t6_clamp_ovf", ovf, 1);
    // step 7 clamped to s=5: 5+5=10 -> 10-6 = 4
    step = 3'd7;
    tick();
    chk("t6_wrap_count", count_out, 4);
    chk("t6_wrap_ovf", ovf, 1);
    // SAT down 4-5 -> 0
    mode = CTR_SAT; up_down = 1'b0;
    tick();
    chk("t6_sat_count", count_out, 0);
    chk("t6_sat_udf", udf, 1);
    chk("t6_sat_ovf", ovf, 0);
    // WRAP down 0-5 -> 0+6-5 = 1
    mode = CTR_WRAP;
    tick();
    chk("wrap_dn_count", count_out, 1);
    chk("wrap_dn_udf", udf, 1);

    // step=0 holds and clears pulses
    step = 3'd0;
    tick();
    chk("step0_count", count_out, 1);
    chk("step0_udf", udf, 0);
    chk("step0_ovf", ovf, 0);

    // limit=0: count forced to 0, both flags set
    ce = 1'b0; limit = 4'd0;
    do_load(4'd3);
    up_down = 1'b1; step = 3'd3; ce = 1'b1;
    tick();
    chk("lim0_count", count_out, 0);
    chk("lim0_max", max_count, 1);
    chk("lim0_zero", zero, 1);
    chk("lim0_ovf", ovf, 0);

    // reset while halted
    ce = 1'b0; limit = 4'd9;
    do_load(4'd8);
    mode = CTR_ONESHOT; step = 3'd1; ce = 1'b1;
    tick();
    chk("halt_pre_done", done, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ce = 1'b0;
    chk("halt_rst_done", done, 0);
    chk("halt_rst_count", count_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
